// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory among three
// requesters (0 = loader/debug, 1 = CPU data, 2 = CPU fetch) via req/ack.
module mem_port_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [1:0]      gnt_id,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] NO_GNT = 2'd3;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic            rd_op;

  logic [2:0]      elig;
  logic            win_valid;
  logic [1:0]      win_id;
  logic [1:0]      idx;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  // Winner search: rr_ptr+1 has top priority, rr_ptr itself the lowest.
  // A requester being acked this cycle is still holding req and is masked.
  always_comb begin
    elig      = req & ~ack;
    win_valid = 1'b0;
    win_id    = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(rr_ptr) + k) % 3);
      if (bit_at(elig, idx)) begin
        win_valid = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (win_id)
      2'd0: begin
        win_we    = we[0];
        win_addr  = addr[0 +: AW];
        win_wdata = wdata[0 +: DW];
      end
      2'd1: begin
        win_we    = we[1];
        win_addr  = addr[AW +: AW];
        win_wdata = wdata[DW +: DW];
      end
      default: begin
        win_we    = we[2];
        win_addr  = addr[2*AW +: AW];
        win_wdata = wdata[2*DW +: DW];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      gnt_id    <= NO_GNT;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= 2'd2;
      rd_op     <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            rd_op     <= ~win_we;
            gnt_id    <= win_id;
            rr_ptr    <= win_id;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= S_RESP;
        end
        S_RESP: begin
          ack <= 3'b001 << gnt_id;
          if (rd_op) rdata <= mem_rdata;
          gnt_id <= NO_GNT;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          gnt_id <= NO_GNT;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and an
// expected-ack scoreboard checked as acks appear.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [1:0]      gnt_id;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: unwritten words hold a fixed address-derived pattern.
  logic [DW-1:0] mem_wr [int];

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5)     return 32'h2009_0007;
    if (a == 'h200) return 32'h0000_0000;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic logic [DW-1:0] mem_val(input int a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_val(int'(mem_addr));
      if (mem_we) mem_wr[int'(mem_addr)] = mem_wdata;
    end
  end

  typedef struct {
    logic [2:0]    ack;
    logic          is_wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [2:0]    hold = '0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic wr, input logic [DW-1:0] d);
    exp_t e;
    e.ack = a; e.is_wr = wr; e.data = d;
    q.push_back(e);
  endtask

  task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    we[id]             = wr;
    addr[id*AW +: AW]  = a;
    wdata[id*DW +: DW] = d;
  endtask

  // One clock: sample 1 time unit after the edge, score any ack, release acked requesters.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ack !== 3'b000) begin
      if (q.size() == 0) begin
        check("unexpected_ack", {29'b0, ack}, 32'd0);
      end else begin
        e = q.pop_front();
        check("ack_id", {29'b0, ack}, {29'b0, e.ack});
        if (!e.is_wr) begin
          check("rdata", rdata, e.data);
          last_rd = e.data;
        end else begin
          check("rdata_hold_wr", rdata, last_rd);
        end
        req = req & ~(ack & ~hold);
        if (q.size() == 0) begin
          req  = '0;
          hold = '0;
        end
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    last_rd = '0;
    check("rst_gnt_id", {30'b0, gnt_id}, 32'd3);
  endtask

  initial begin
    int ta[3];
    int ord;

    // Reset held with every requester asking.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ack",    {29'b0, ack},    32'd0);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_gnt_id", {30'b0, gnt_id}, 32'd3);
      check("rst_busy",   {31'b0, busy},   32'd0);
    end
    check("rst_rdata", rdata, 32'd0);
    req   = '0;
    rst_n = 1'b1;
    tick();

    // Single instruction fetch.
    set_req(2, 1'b0, 10'h005, '0);
    req[2] = 1'b1;
    push(3'b100, 1'b0, 32'h2009_0007);
    tick();
    check("fetch_mem_en",   {31'b0, mem_en},   32'd1);
    check("fetch_mem_we",   {31'b0, mem_we},   32'd0);
    check("fetch_mem_addr", {22'b0, mem_addr}, 32'h005);
    check("fetch_gnt_id",   {30'b0, gnt_id},   32'd2);
    check("fetch_busy",     {31'b0, busy},     32'd1);
    tick();
    check("fetch_issue_done", {31'b0, mem_en}, 32'd0);
    tick();
    check("fetch_ack",   {29'b0, ack}, 32'b100);
    check("fetch_rdata", rdata,        32'h2009_0007);

    // All three at once after reset: grants 0,1,2 spaced three cycles.
    do_reset();
    set_req(0, 1'b0, 10'h010, '0);
    set_req(1, 1'b0, 10'h020, '0);
    set_req(2, 1'b0, 10'h030, '0);
    req = 3'b111;
    push(3'b001, 1'b0, init_val('h010));
    push(3'b010, 1'b0, init_val('h020));
    push(3'b100, 1'b0, init_val('h030));
    ord = 0;
    for (int c = 0; c < 30 && q.size() > 0; c++) begin
      tick();
      if (ack !== 3'b000 && ord < 3) begin
        ta[ord] = c;
        ord++;
      end
    end
    check("all3_drain", 32'(q.size()), 32'd0);
    check("all3_gap01", 32'(ta[1] - ta[0]), 32'd3);
    check("all3_gap12", 32'(ta[2] - ta[1]), 32'd3);

    // Fairness: 1 and 2 requesting continuously for eight grants.
    do_reset();
    set_req(1, 1'b0, 10'h040, '0);
    set_req(2, 1'b0, 10'h041, '0);
    hold = 3'b110;
    req  = 3'b110;
    for (int g = 0; g < 4; g++) begin
      push(3'b010, 1'b0, init_val('h040));
      push(3'b100, 1'b0, init_val('h041));
    end
    drain(60);

    // Write then read of the same word; last winner was 2 so 1 goes first.
    set_req(1, 1'b1, 10'h3FD, 32'hDEAD_BEEF);
    set_req(2, 1'b0, 10'h3FD, '0);
    req = 3'b110;
    push(3'b010, 1'b1, '0);
    push(3'b100, 1'b0, 32'hDEAD_BEEF);
    tick();
    check("wr_mem_en",    {31'b0, mem_en},   32'd1);
    check("wr_mem_we",    {31'b0, mem_we},   32'd1);
    check("wr_mem_addr",  {22'b0, mem_addr}, 32'h3FD);
    check("wr_mem_wdata", mem_wdata,         32'hDEAD_BEEF);
    check("wr_gnt_id",    {30'b0, gnt_id},   32'd1);
    tick();
    tick();
    tick();
    check("rd_mem_en",   {31'b0, mem_en}, 32'd1);
    check("rd_mem_we",   {31'b0, mem_we}, 32'd0);
    check("rd_gnt_id",   {30'b0, gnt_id}, 32'd2);
    drain(20);

    // Reset during RESP of a read: prior rdata is a completed read of zero.
    set_req(0, 1'b0, 10'h200, '0);
    req[0] = 1'b1;
    push(3'b001, 1'b0, 32'h0);
    drain(20);
    set_req(0, 1'b0, 10'h011, '0);
    req[0] = 1'b1;
    tick();
    tick();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    req   = '0;
    tick();
    check("midrst_ack",    {29'b0, ack},    32'd0);
    check("midrst_rdata",  rdata,           last_rd);
    check("midrst_busy",   {31'b0, busy},   32'd0);
    check("midrst_gnt_id", {30'b0, gnt_id}, 32'd3);
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", {29'b0, ack}, 32'd0);
    set_req(0, 1'b0, 10'h012, '0);
    set_req(1, 1'b0, 10'h013, '0);
    req = 3'b011;
    push(3'b001, 1'b0, init_val('h012));
    push(3'b010, 1'b0, init_val('h013));
    tick();
    check("post_rst_gnt0", {30'b0, gnt_id}, 32'd0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
